// File: rtl/issue_fifo.sv
// issue_fifo: in-order issue queue with show-ahead head, almost-full stall hint and redirect flush.
module issue_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty       = count == '0;
    assign full        = count == CW'(DEPTH);
    assign almost_full = (CW'(DEPTH) - count) <= CW'(AF_MARGIN);
    assign do_pop      = pop & ~empty;
    assign do_push     = push & (~full | do_pop);
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= wr_ptr;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(do_push) - CW'(do_pop);
            overflow <= push & full & ~do_pop;
        end
    end

    // storage is deliberately left unreset; its contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push)
            mem[wr_ptr] <= din;
    end
endmodule

// File: tb/tb_issue_fifo.sv
// tb_issue_fifo: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_issue_fifo;
    localparam int DEPTH = 8;
    localparam int AF    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        push = 1'b0;
    logic [31:0] din = '0;
    logic        pop = 1'b0;
    logic [31:0] dout;
    logic        empty, full, almost_full, overflow;
    logic [3:0]  count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    logic        m_ovf = 1'b0;
    logic        prev_full;

    issue_fifo #(.WIDTH(32), .DEPTH(DEPTH), .AF_MARGIN(AF)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .din(din), .pop(pop),
        .dout(dout), .empty(empty), .full(full), .almost_full(almost_full),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    always @(posedge clk or posedge rst)
        if (rst) prev_full <= 1'b0;
        else     prev_full <= full;

    // structural invariants observed every cycle, mid-period
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (count > 4'(DEPTH) || (empty && full) || (overflow && !prev_full)) begin
                n_err++;
                $display("FAIL invariant: count=%0d empty=%0b full=%0b ovf=%0b prev_full=%0b, expected count<=8, not empty&full, ovf only after full",
                         count, empty, full, overflow, prev_full);
            end
        end
    end

    // drive one clock of stimulus and advance the reference model on pre-edge state
    task automatic cycle(input logic p, input logic [31:0] d, input logic pp, input logic f);
        int sz;
        logic dp, dq;
        push = p; din = d; pop = pp; flush = f;
        @(posedge clk);
        sz = q.size();
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            dp = pp && sz > 0;
            dq = p && (sz < DEPTH || dp);
            if (dp) void'(q.pop_front());
            if (dq) q.push_back(d);
            m_ovf = p && sz == DEPTH && !dp;
        end
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({empty, full, almost_full, overflow, count} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL reset: got e/f/af/ov/cnt=%b%b%b%b/%0d, expected 1000/0", empty, full, almost_full, overflow, count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 32'h10 + i, 0, 0);
            n_cmp++;
            if (count !== 4'(i + 1) || full !== (i == DEPTH - 1) || almost_full !== (i + 1 >= DEPTH - AF) || dout !== 32'h10) begin
                n_err++;
                $display("FAIL fill[%0d]: got cnt=%0d f=%b af=%b dout=%h, expected cnt=%0d f=%b af=%b dout=10",
                         i, count, full, almost_full, dout, i + 1, i == DEPTH - 1, i + 1 >= DEPTH - AF);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dout !== 32'h10 + i) begin
                n_err++;
                $display("FAIL drain[%0d]: got dout=%h, expected %h", i, dout, 32'h10 + i);
            end
            cycle(0, 0, 1, 0);
        end
        n_cmp++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            n_err++;
            $display("FAIL drain_empty: got empty=%b cnt=%0d, expected 1/0", empty, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'h10 + i, 0, 0);
        cycle(1, 32'hAA, 0, 0);
        n_cmp++;
        if (overflow !== 1'b1 || count !== 4'd8 || dout !== 32'h10) begin
            n_err++;
            $display("FAIL overflow_pulse: got ov=%b cnt=%0d dout=%h, expected 1/8/10", overflow, count, dout);
        end
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            n_err++;
            $display("FAIL overflow_clear: got ov=%b cnt=%0d, expected 0/8", overflow, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [8] = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h20};
        cycle(1, 32'h20, 1, 0);
        n_cmp++;
        if (count !== 4'd8 || dout !== 32'h11 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_pushpop: got cnt=%0d dout=%h ov=%b, expected 8/11/0", count, dout, overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (dout !== exp[i]) begin
                n_err++;
                $display("FAIL full_drain[%0d]: got dout=%h, expected %h", i, dout, exp[i]);
            end
            cycle(0, 0, 1, 0);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) cycle(1, 32'h30 + i, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 32'h33 + i, 1, 0);
            n_cmp++;
            if (dout !== 32'h31 + i || count !== 4'd3) begin
                n_err++;
                $display("FAIL wrap[%0d]: got dout=%h cnt=%0d, expected %h/3", i, dout, count, 32'h31 + i);
            end
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_empty: got empty=%b, expected 1", empty);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1, 32'h40 + i, 0, 0);
        cycle(1, 32'h55, 1, 1);
        n_cmp++;
        if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL flush: got e=%b cnt=%0d ov=%b, expected 1/0/0", empty, count, overflow);
        end
        cycle(1, 32'h66, 0, 0);
        n_cmp++;
        if (dout !== 32'h66 || count !== 4'd1) begin
            n_err++;
            $display("FAIL flush_push: got dout=%h cnt=%0d, expected 66/1", dout, count);
        end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h50 + i, 0, 0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (empty !== 1'b1 || count !== 4'd0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got e=%b cnt=%0d f=%b, expected 1/0/0", empty, count, full);
        end
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        cycle(1, 32'h77, 0, 0);
        n_cmp++;
        if (dout !== 32'h77 || count !== 4'd1) begin
            n_err++;
            $display("FAIL reset_push: got dout=%h cnt=%0d, expected 77/1", dout, count);
        end
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
            n_cmp++;
            if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                almost_full !== (DEPTH - q.size() <= AF) || overflow !== m_ovf ||
                (q.size() != 0 && dout !== q[0])) begin
                n_err++;
                $display("FAIL random[%0d]: got cnt=%0d e=%b f=%b af=%b ov=%b dout=%h, expected cnt=%0d ov=%b head=%h",
                         i, count, empty, full, almost_full, overflow, dout, q.size(), m_ovf,
                         q.size() != 0 ? q[0] : 32'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
